// File: rtl/spi_ram_burst_slave_if.sv
// ============================================================================
// spi_ram_burst_slave_if : SPI pin bundle (select, data in/out, error pulse)
// Rev 1.0
// ============================================================================
`default_nettype none

interface spi_ram_burst_slave_if;
    logic SS_n;
    logic MOSI;
    logic MISO;
    logic frame_err;

    modport master (output SS_n, output MOSI, input MISO, input frame_err);
    modport slave  (input SS_n, input MOSI, output MISO, output frame_err);
endinterface

`default_nettype wire

// File: rtl/spi_ram_burst_slave.sv
// ============================================================================
// spi_ram_burst_slave : burst-capable SPI-slave RAM with auto-increment pointers
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_ram_burst_slave #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE  = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    spi_ram_burst_slave_if.slave      spi
);

    localparam int SW = (DATA_WIDTH > ADDR_SIZE) ? DATA_WIDTH : ADDR_SIZE;
    localparam int CW = $clog2(SW) + 1;
    localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_ADDR    = 3'd2,
        S_WDATA   = 3'd3,
        S_RDATA   = 3'd4,
        S_DISCARD = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic                   armed_q, armed_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [1:0]             op_q, op_d;
    logic [SW-1:0]          shift_q, shift_d;
    logic [ADDR_SIZE-1:0]   wptr_q, wptr_d;
    logic [ADDR_SIZE-1:0]   rptr_q, rptr_d;
    logic                   miso_q, miso_d;
    logic                   ferr_q, ferr_d;
    logic                   mem_we;
    logic [DATA_WIDTH-1:0]  mem_wdata;
    logic [ADDR_SIZE-1:0]   addr_w;
    logic [DATA_WIDTH-1:0]  rdata_w;

    logic [DATA_WIDTH-1:0]  mem_q [MEM_DEPTH];

    function automatic logic [ADDR_SIZE-1:0] ptr_inc(input logic [ADDR_SIZE-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign rdata_w       = mem_q[rptr_q];
    assign spi.MISO      = miso_q;
    assign spi.frame_err = ferr_q;

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        shift_d   = shift_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        miso_d    = 1'b0;
        ferr_d    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = {shift_q[DATA_WIDTH-2:0], spi.MOSI};
        addr_w    = {shift_q[ADDR_SIZE-2:0], spi.MOSI};

        if (spi.SS_n) begin
            // Frame end: a partially shifted address or data word is a protocol error.
            state_d = S_IDLE;
            armed_d = 1'b1;
            cnt_d   = '0;
            if ((state_q == S_ADDR || state_q == S_WDATA) && cnt_q != '0)
                ferr_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (armed_q) begin
                        state_d = S_CMD;
                        op_d    = {1'b0, spi.MOSI};
                        cnt_d   = CW'(1);
                    end
                end
                S_CMD: begin
                    if (cnt_q == CW'(1)) begin
                        op_d  = {op_q[0], spi.MOSI};
                        cnt_d = CW'(2);
                    end else begin
                        cnt_d = '0;
                        case ({op_q, spi.MOSI})
                            3'b000, 3'b110: state_d = S_ADDR;
                            3'b001:         state_d = S_WDATA;
                            3'b111:         state_d = S_RDATA;
                            default: begin
                                state_d = S_DISCARD;
                                ferr_d  = 1'b1;
                            end
                        endcase
                    end
                end
                S_ADDR: begin
                    shift_d = {shift_q[SW-2:0], spi.MOSI};
                    if (cnt_q == CW'(ADDR_SIZE - 1)) begin
                        state_d = S_DISCARD;
                        cnt_d   = '0;
                        if ({1'b0, addr_w} < (ADDR_SIZE + 1)'(MEM_DEPTH)) begin
                            if (op_q[1]) rptr_d = addr_w;
                            else         wptr_d = addr_w;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WDATA: begin
                    shift_d = {shift_q[SW-2:0], spi.MOSI};
                    if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                        mem_we = 1'b1;
                        wptr_d = ptr_inc(wptr_q);
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_RDATA: begin
                    // Word boundary: fetch next word and drive its MSB on the same edge.
                    if (cnt_q == '0) begin
                        miso_d                   = rdata_w[DATA_WIDTH-1];
                        shift_d[DATA_WIDTH-1:0]  = {rdata_w[DATA_WIDTH-2:0], 1'b0};
                        rptr_d                   = ptr_inc(rptr_q);
                    end else begin
                        miso_d                   = shift_q[DATA_WIDTH-1];
                        shift_d[DATA_WIDTH-1:0]  = {shift_q[DATA_WIDTH-2:0], 1'b0};
                    end
                    cnt_d = (cnt_q == CW'(DATA_WIDTH - 1)) ? '0 : cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            op_q    <= '0;
            shift_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            miso_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            shift_q <= shift_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            miso_q  <= miso_d;
            ferr_q  <= ferr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && mem_we)
            mem_q[wptr_q] <= mem_wdata;
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_ram_burst_slave.sv
// ============================================================================
// tb_spi_ram_burst_slave : directed self-checking bench, default and depth-200 instances
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_spi_ram_burst_slave;

    logic clk;
    logic rst_n;
    int   ncmp;
    int   nfail;
    int   ecnt0;
    logic [63:0] mi;
    logic [63:0] fe;
    logic        fe1;

    spi_ram_burst_slave_if bus0 ();
    spi_ram_burst_slave_if bus1 ();

    spi_ram_burst_slave u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .spi   (bus0.slave)
    );

    spi_ram_burst_slave #(.DATA_WIDTH(8), .ADDR_SIZE(8), .MEM_DEPTH(200)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .spi   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus0.frame_err === 1'b1) ecnt0++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic ss, input logic d);
        if (sel == 1) begin bus1.SS_n = ss; bus1.MOSI = d; end
        else          begin bus0.SS_n = ss; bus0.MOSI = d; end
    endtask

    task automatic xfer(input int sel, input int n, input logic [63:0] d,
                        output logic [63:0] m, output logic [63:0] f);
        m = '0;
        f = '0;
        for (int i = 0; i < n; i++) begin
            drive(sel, 1'b0, d[n-1-i]);
            @(posedge clk); #1;
            m = {m[62:0], (sel == 1) ? bus1.MISO : bus0.MISO};
            f = {f[62:0], (sel == 1) ? bus1.frame_err : bus0.frame_err};
        end
    endtask

    task automatic end_frame(input int sel, output logic f);
        drive(sel, 1'b1, 1'b0);
        @(posedge clk); #1;
        f = (sel == 1) ? bus1.frame_err : bus0.frame_err;
    endtask

    initial begin
        ncmp  = 0;
        nfail = 0;
        ecnt0 = 0;
        rst_n = 1'b0;
        drive(0, 1'b1, 1'b0);
        drive(1, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_miso",  {63'd0, bus0.MISO}, 64'd0);
        check("rst_ferr",  {63'd0, bus0.frame_err}, 64'd0);
        check("rst_wptr",  64'(u0.wptr_q), 64'd0);
        check("rst_rptr",  64'(u0.rptr_q), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: address set and three-word burst write
        xfer(0, 11, {3'b000, 8'hD7}, mi, fe);                 end_frame(0, fe1);
        xfer(0, 27, {3'b001, 8'hCB, 8'h12, 8'h34}, mi, fe);
        check("t1_ferr_bits", fe, 64'd0);
        end_frame(0, fe1);
        check("t1_mem_d7", 64'(u0.mem_q[8'hD7]), 64'hCB);
        check("t1_mem_d8", 64'(u0.mem_q[8'hD8]), 64'h12);
        check("t1_mem_d9", 64'(u0.mem_q[8'hD9]), 64'h34);
        check("t1_wptr",   64'(u0.wptr_q), 64'hDA);

        // 2: burst read back
        xfer(0, 11, {3'b110, 8'hD7}, mi, fe);                 end_frame(0, fe1);
        xfer(0, 27, {3'b111, 24'hFFFFFF}, mi, fe);
        check("t2_read",      mi[26:0], {3'b000, 24'hCB1234});
        end_frame(0, fe1);
        check("t2_rptr",      64'(u0.rptr_q), 64'hDA);

        // 3: pointer wrap, full depth
        xfer(0, 11, {3'b000, 8'hFF}, mi, fe);                 end_frame(0, fe1);
        xfer(0, 19, {3'b001, 8'hAA, 8'h55}, mi, fe);          end_frame(0, fe1);
        check("t3_mem_ff", 64'(u0.mem_q[8'hFF]), 64'hAA);
        check("t3_mem_00", 64'(u0.mem_q[8'h00]), 64'h55);
        xfer(0, 11, {3'b110, 8'hFF}, mi, fe);                 end_frame(0, fe1);
        xfer(0, 19, {3'b111, 16'h0000}, mi, fe);              end_frame(0, fe1);
        check("t3_read_wrap", 64'(mi[15:0]), 64'hAA55);

        // 3b: wrap at depth 200, out-of-range address
        xfer(1, 11, {3'b000, 8'hC7}, mi, fe);                 end_frame(1, fe1);
        xfer(1, 19, {3'b001, 8'hAA, 8'h55}, mi, fe);          end_frame(1, fe1);
        check("t3b_mem_c7", 64'(u1.mem_q[199]), 64'hAA);
        check("t3b_mem_00", 64'(u1.mem_q[0]), 64'h55);
        check("t3b_wptr",   64'(u1.wptr_q), 64'h01);
        xfer(1, 11, {3'b000, 8'hC8}, mi, fe);
        check("t3b_oor_ferr", fe[10:0], 64'h001);
        end_frame(1, fe1);
        check("t3b_wptr_kept", 64'(u1.wptr_q), 64'h01);
        xfer(1, 11, {3'b110, 8'hC7}, mi, fe);                 end_frame(1, fe1);
        xfer(1, 19, {3'b111, 16'h0000}, mi, fe);              end_frame(1, fe1);
        check("t3b_read_wrap", 64'(mi[15:0]), 64'hAA55);

        // 4: illegal opcode
        xfer(0, 11, {3'b010, 8'hA5}, mi, fe);
        check("t4_ferr_edge3", fe[10:0], 64'h100);
        check("t4_miso",       mi[10:0], 64'h000);
        end_frame(0, fe1);
        check("t4_ferr_end",   {63'd0, fe1}, 64'd0);
        check("t4_wptr",       64'(u0.wptr_q), 64'h01);
        check("t4_rptr",       64'(u0.rptr_q), 64'h01);
        check("t4_mem_00",     64'(u0.mem_q[8'h00]), 64'h55);
        check("t4_pulse_cnt",  64'(ecnt0), 64'd1);

        // 5: write truncated mid-word
        xfer(0, 11, {3'b000, 8'h02}, mi, fe);                 end_frame(0, fe1);
        xfer(0, 11, {3'b001, 8'h77}, mi, fe);                 end_frame(0, fe1);
        xfer(0, 11, {3'b000, 8'h01}, mi, fe);                 end_frame(0, fe1);
        xfer(0, 16, {3'b001, 8'h3C, 5'b10101}, mi, fe);
        check("t5_ferr_bits", fe, 64'd0);
        end_frame(0, fe1);
        check("t5_ferr_trunc", {63'd0, fe1}, 64'd1);
        check("t5_mem_01",     64'(u0.mem_q[8'h01]), 64'h3C);
        check("t5_mem_02",     64'(u0.mem_q[8'h02]), 64'h77);
        check("t5_wptr",       64'(u0.wptr_q), 64'h02);

        // 6: reset in the middle of a read
        xfer(0, 11, {3'b110, 8'hD7}, mi, fe);                 end_frame(0, fe1);
        xfer(0, 7, {3'b111, 4'h0}, mi, fe);
        check("t6_partial_read", 64'(mi[3:0]), 64'hC);
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("t6_rst_miso", {63'd0, bus0.MISO}, 64'd0);
        check("t6_rst_rptr", 64'(u0.rptr_q), 64'd0);
        check("t6_rst_wptr", 64'(u0.wptr_q), 64'd0);
        rst_n = 1'b1;
        xfer(0, 11, {3'b001, 8'hFF}, mi, fe);
        check("t6_ignored_miso", mi[10:0], 64'd0);
        check("t6_ignored_ferr", fe[10:0], 64'd0);
        end_frame(0, fe1);
        check("t6_wptr_after",  64'(u0.wptr_q), 64'd0);
        check("t6_mem_00_kept", 64'(u0.mem_q[8'h00]), 64'h55);
        xfer(0, 11, {3'b110, 8'hD7}, mi, fe);                 end_frame(0, fe1);
        xfer(0, 15, {3'b111, 12'h000}, mi, fe);
        check("t6_read_retained", 64'(mi[11:0]), 64'hCB1);
        end_frame(0, fe1);
        check("t6_read_trunc_ok", {63'd0, fe1}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_ram_burst_slave.md
# spi_ram_burst_slave

SPI-slave memory endpoint that replaces the single-word wrapper with a parametrised, burst-capable version. Word width, address width and memory depth are parameters. Separate write and read pointers auto-increment, so one frame can stream any number of words. Sits between the board-level SPI pins and on-chip storage: it decodes the 3-bit opcode, holds the storage array and shifts read data out on MISO.

## Interface
- DATA_WIDTH, 8, bits per memory word and per SPI data word
- ADDR_SIZE, 8, bits in an address payload; MEM_DEPTH ≤ 2**ADDR_SIZE
- MEM_DEPTH, 256, number of words in the array
- clk  input  1  system clock; also the SPI bit clock (MOSI sampled on rising edge)
- rst_n  input  1  synchronous, active-low reset
- SS_n  input  1  slave select, active low; frame = contiguous cycles with SS_n low
- MOSI  input  1  serial data in, MSB first
- MISO  output  1  serial data out, MSB first, registered
- frame_err  output  1  one-cycle pulse on protocol error

## Operation
- Edge numbering: edge n is the n-th rising clk edge that samples SS_n low in the current frame.
- Edges 1–3 sample the opcode:
  - 000 SET_WADDR
  - 001 WRITE
  - 110 SET_RADDR
  - 111 READ
  - any other opcode is illegal.
- States: IDLE, CMD, ADDR, WDATA, RDATA, DISCARD.
  - IDLE→CMD on SS_n low while armed; CMD exits after edge 3.
  - Any state→IDLE on any edge that samples SS_n high.
- armed:
  - cleared by reset; set by any edge that samples SS_n high.
  - A frame already in progress at reset release is ignored until SS_n has been high at least once.
- SET_WADDR / SET_RADDR:
  - Edges 4..3+ADDR_SIZE shift in the address.
  - On edge 3+ADDR_SIZE the pointer loads the address, or stays unchanged with a frame_err pulse if the address ≥ MEM_DEPTH.
  - Then DISCARD until SS_n high.
- WRITE:
  - Each DATA_WIDTH-bit group from edge 4 onward is one word.
  - On the edge sampling a word's last bit: mem[wptr] ← {shift, MOSI} and wptr ← wptr+1.
  - Words stream back-to-back without limit.
- READ:
  - On edge 4: shift ← mem[rptr], rptr ← rptr+1, MISO ← MSB.
  - One bit per edge after that.
  - On edge 4+k·DATA_WIDTH the next word loads with no gap.
  - MOSI is ignored.
- Pointer arithmetic: both pointers wrap MEM_DEPTH−1 → 0 (not a power-of-two modulus when MEM_DEPTH < 2**ADDR_SIZE).
- Illegal opcode: frame_err pulses on edge 3, then DISCARD. No state change, MISO stays 0.
- Truncation: SS_n rising in ADDR or WDATA with a partial word:
  - The partial bits are dropped and frame_err pulses on that edge.
  - Words already completed stay committed.
  - Truncating READ is not an error.
- Memory is not cleared by reset.

## Timing
- Reset values: MISO 0, frame_err 0, wptr 0, rptr 0, state IDLE, armed 0, shift registers 0.
- Write latency: data is in the array on the same edge that samples the last bit, so a READ in the next frame returns it.
- Read latency: the first MISO bit is valid after edge 4 (one cycle after the final opcode bit is sampled).
  - Word j, bit i (i=0 is MSB) is driven from edge 4+j·DATA_WIDTH+i until the next edge.
- MISO goes to 0 on the first edge that samples SS_n high, and is 0 in every state except RDATA.
- frame_err is high for exactly one cycle per error and never asserts outside the conditions above.
- Reset mid-frame wins over every other action:
  - MISO is 0 after the reset edge.
  - Pointers are 0; memory is retained.
- SS_n high for a single cycle between frames is sufficient; back-to-back frames need no idle gap beyond it.

## Test plan
1. Defaults (8/8/256). SET_WADDR 0xD7 (000 11010111), then WRITE 0xCB, 0x12, 0x34 in one frame -> mem[0xD7]=0xCB, mem[0xD8]=0x12, mem[0xD9]=0x34, wptr=0xDA, frame_err never high.
2. SET_RADDR 0xD7, then READ for 24 data edges -> MISO bits from edge 4 are 11001011 00010010 00110100; rptr=0xDA.
3. Wrap. SET_WADDR 0xFF, WRITE 0xAA, 0x55 -> mem[0xFF]=0xAA, mem[0x00]=0x55. A READ from 0xFF returns 0xAA then 0x55. Repeat with MEM_DEPTH=200 from 0xC7: second word lands at 0x00. SET_WADDR 0xC8 -> frame_err pulse, wptr unchanged.
4. Illegal opcode 010 followed by 8 bits -> frame_err pulse on edge 3, MISO 0 all frame, memory and pointers unchanged.
5. WRITE 0x3C complete, then SS_n high after 5 bits of a second word -> mem[wptr0]=0x3C, wptr=wptr0+1, frame_err pulse on the SS_n-high edge, second word not written.
6. rst_n low one cycle mid-READ with SS_n held low -> MISO 0 from the reset edge. Remaining MOSI bits are ignored until SS_n goes high. A following SET_RADDR 0xD7 / READ frame pair still returns 0xCB (memory retained).
